// File: rtl/fmul_pkg.sv
// Shared widths, field positions and record types for the FMUL scheduler.
package fmul_pkg;

  localparam int unsigned FLOAT_W  = 24;
  localparam int unsigned EXP_W    = 7;
  localparam int unsigned MANT_W   = 16;

  localparam int unsigned SIGN_POS = 23;
  localparam int unsigned EXP_MSB  = 22;
  localparam int unsigned EXP_LSB  = 16;
  localparam int unsigned MANT_MSB = 15;
  localparam int unsigned MANT_LSB = 0;

  // Response record: result plus overflow and underflow flags.
  localparam int unsigned RESP_W   = FLOAT_W + 2;

  typedef logic [FLOAT_W-1:0] float_t;

  typedef struct packed {
    float_t data;
    logic   ovf;
    logic   unf;
  } resp_t;

  // In-flight marker travelling alongside the multiplier pipeline.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/fmul_scheduler_if.sv
// Requester, multiplier and response signals of the FMUL scheduler.
// master = surrounding system (requesters, multiplier, response sinks); slave = scheduler.
interface fmul_scheduler_if;
  import fmul_pkg::*;

  logic   req0_valid, req0_ready, req1_valid, req1_ready;
  float_t req0_a, req0_b, req1_a, req1_b;

  float_t mul_a, mul_b, mul_result;
  logic   mul_overflow, mul_underflow;

  logic   resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  float_t resp0_data, resp1_data;
  logic   resp0_ovf, resp0_unf, resp1_ovf, resp1_unf;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output mul_result, mul_overflow, mul_underflow,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready, mul_a, mul_b,
    input  resp0_valid, resp0_data, resp0_ovf, resp0_unf,
    input  resp1_valid, resp1_data, resp1_ovf, resp1_unf
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  mul_result, mul_overflow, mul_underflow,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready, mul_a, mul_b,
    output resp0_valid, resp0_data, resp0_ovf, resp0_unf,
    output resp1_valid, resp1_data, resp1_ovf, resp1_unf
  );

endinterface

// File: rtl/fmul_resp_fifo.sv
// Per-requester response FIFO; extra pointer bit separates full from empty.
module fmul_resp_fifo
  import fmul_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  resp_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output resp_t head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  resp_t         mem_q [DEPTH];
  resp_t         mem_d [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
  end

  // Storage cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/fmul_scheduler.sv
// Shares one fixed-latency multiplier between two requesters: round-robin
// arbitration, credit flow control and a tag pipeline steering results home.
module fmul_scheduler
  import fmul_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 4
) (
  input logic             clk,
  input logic             rst,
  fmul_scheduler_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          ptr_q, ptr_d;
  logic [CW-1:0] credit0_q, credit0_d, credit1_q, credit1_d;
  float_t        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  // Stage 0 travels with mul_a/mul_b; stages 1..LATENCY mirror the multiplier.
  tag_t          tag_q [LATENCY+1];
  tag_t          tag_d [LATENCY+1];

  logic  elig0, elig1, grant0, grant1, acc0, acc1;
  logic  pop0, pop1, push0, push1;
  logic  full0, full1, empty0, empty1;
  resp_t head0, head1, wr_rec;

  // Round-robin grant among requesters that are valid and hold credit.
  always_comb begin
    elig0  = bus.req0_valid && (credit0_q != '0);
    elig1  = bus.req1_valid && (credit1_q != '0);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (!ptr_q) begin
        grant0 = elig0;
        grant1 = !elig0 && elig1;
      end else begin
        grant1 = elig1;
        grant0 = !elig1 && elig0;
      end
    end
  end

  assign acc0 = grant0 && bus.req0_valid;
  assign acc1 = grant1 && bus.req1_valid;

  // Pointer, credits, operand registers and tag pipeline advance.
  always_comb begin
    pop0      = !empty0 && bus.resp0_ready;
    pop1      = !empty1 && bus.resp1_ready;
    ptr_d     = ptr_q;
    if (acc0) begin
      ptr_d = 1'b1;
    end else if (acc1) begin
      ptr_d = 1'b0;
    end
    credit0_d = credit0_q - CW'(acc0) + CW'(pop0);
    credit1_d = credit1_q - CW'(acc1) + CW'(pop1);
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    if (acc0) begin
      mul_a_d = bus.req0_a;
      mul_b_d = bus.req0_b;
    end else if (acc1) begin
      mul_a_d = bus.req1_a;
      mul_b_d = bus.req1_b;
    end
    tag_d[0].valid = acc0 || acc1;
    tag_d[0].id    = acc1;
    for (int unsigned i = 1; i <= LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Multiplier output captured into the FIFO named by the exiting tag.
  always_comb begin
    wr_rec.data = bus.mul_result;
    wr_rec.ovf  = bus.mul_overflow;
    wr_rec.unf  = bus.mul_underflow;
    push0       = tag_q[LATENCY].valid && !tag_q[LATENCY].id;
    push1       = tag_q[LATENCY].valid && tag_q[LATENCY].id;
  end

  // State registers; reset drops every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= 1'b0;
      credit0_q <= CW'(DEPTH);
      credit1_q <= CW'(DEPTH);
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      credit0_q <= credit0_d;
      credit1_q <= credit1_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  fmul_resp_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .push(push0), .push_data(wr_rec), .pop(pop0),
    .full(full0), .empty(empty0), .head(head0)
  );

  fmul_resp_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push(push1), .push_data(wr_rec), .pop(pop1),
    .full(full1), .empty(empty1), .head(head1)
  );

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.resp0_valid = !empty0;
  assign bus.resp0_data  = head0.data;
  assign bus.resp0_ovf   = head0.ovf;
  assign bus.resp0_unf   = head0.unf;
  assign bus.resp1_valid = !empty1;
  assign bus.resp1_data  = head1.data;
  assign bus.resp1_ovf   = head1.ovf;
  assign bus.resp1_unf   = head1.unf;

  // Credits reserve a slot per op, so a push never meets a full FIFO without a pop.
  a_no_ovf0: assert property (@(posedge clk) disable iff (rst) !(push0 && full0 && !pop0));
  a_no_ovf1: assert property (@(posedge clk) disable iff (rst) !(push1 && full1 && !pop1));

endmodule

// File: tb/tb_fmul_scheduler.sv
// Directed bench for fmul_scheduler with a toy fixed-latency multiplier model.
module tb_fmul_scheduler;
  import fmul_pkg::*;

  localparam int unsigned LAT = 4;
  localparam int unsigned DEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fmul_scheduler_if bus();

  fmul_scheduler #(.LATENCY(LAT), .DEPTH(DEP)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Toy multiply: sign xor, biased exponent sum (bias 63), mantissa xor; flags from exponent range.
  function automatic logic [25:0] model(input float_t a, input float_t b);
    int unsigned e;
    logic [6:0]  er;
    e  = 32'(a[22:16]) + 32'(b[22:16]);
    er = 7'(e - 63);
    return {a[23] ^ b[23], er, a[15:0] ^ b[15:0], e > 190, e < 63};
  endfunction

  // Multiplier: result for operands on mul_a/mul_b appears LAT cycles later.
  logic [25:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= model(bus.mul_a, bus.mul_b);
    for (int i = 1; i < int'(LAT); i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_result    = mpipe[LAT-1][25:2];
  assign bus.mul_overflow  = mpipe[LAT-1][1];
  assign bus.mul_underflow = mpipe[LAT-1][0];

  // Scoreboard: expected records queued at acceptance, compared at response handshake.
  logic [25:0] exp0_q[$];
  logic [25:0] exp1_q[$];
  int          acc0_n = 0;
  int          acc1_n = 0;
  bit          log_en = 1'b0;
  bit          acc_log[$];
  logic        a0, a1;

  always @(posedge clk) begin
    if (rst) begin
      exp0_q.delete();
      exp1_q.delete();
    end else begin
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      if (a0 || a1) chk("one_acc", 32'(a0 && a1), 32'd0);
      if (a0) begin
        exp0_q.push_back(model(bus.req0_a, bus.req0_b));
        acc0_n <= acc0_n + 1;
        if (log_en) acc_log.push_back(1'b0);
      end
      if (a1) begin
        exp1_q.push_back(model(bus.req1_a, bus.req1_b));
        acc1_n <= acc1_n + 1;
        if (log_en) acc_log.push_back(1'b1);
      end
      if (bus.resp0_valid && bus.resp0_ready) begin
        if (exp0_q.size() == 0) chk("sb0_extra", 32'd1, 32'd0);
        else chk("sb0_rec", 32'({bus.resp0_data, bus.resp0_ovf, bus.resp0_unf}), 32'(exp0_q.pop_front()));
      end
      if (bus.resp1_valid && bus.resp1_ready) begin
        if (exp1_q.size() == 0) chk("sb1_extra", 32'd1, 32'd0);
        else chk("sb1_rec", 32'({bus.resp1_data, bus.resp1_ovf, bus.resp1_unf}), 32'(exp1_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair and hold it until accepted (bounded).
  task automatic send(input bit id, input float_t a, input float_t b);
    int n = 0;
    if (id) begin bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
    else    begin bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
    tick();
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit id, input string tag);
    int n = 0;
    while (!(id ? bus.resp1_valid : bus.resp0_valid) && n < 30) begin
      tick();
      n++;
    end
    if (n >= 30) chk(tag, 32'd0, 32'd1);
  endtask

  int base0, base1;

  initial begin
    // Reset with requests pending: nothing ready, all outputs zero.
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_a = 24'h123456; bus.req0_b = 24'h654321;
    bus.req1_a = 24'h111111; bus.req1_b = 24'h222222;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy0", 32'(bus.req0_ready), 32'd0);
    chk("rst_rdy1", 32'(bus.req1_ready), 32'd0);
    chk("rst_rvalid", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
    chk("rst_mula", 32'(bus.mul_a), 32'd0);
    chk("rst_mulb", 32'(bus.mul_b), 32'd0);
    chk("rst_resp0", 32'({bus.resp0_data, bus.resp0_ovf, bus.resp0_unf}), 32'd0);
    chk("rst_resp1", 32'({bus.resp1_data, bus.resp1_ovf, bus.resp1_unf}), 32'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single req0 op: operands registered at accept, response after LAT+1 more edges.
    bus.req0_a = 24'h3F8000; bus.req0_b = 24'h400000; bus.req0_valid = 1'b1;
    #1;
    chk("t1_rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    chk("t1_mula", 32'(bus.mul_a), 32'h3F8000);
    chk("t1_mulb", 32'(bus.mul_b), 32'h400000);
    for (int k = 1; k <= int'(LAT); k++) begin
      tick();
      chk("t1_early", 32'(bus.resp0_valid), 32'd0);
    end
    tick();
    chk("t1_valid", 32'(bus.resp0_valid), 32'd1);
    chk("t1_rec", 32'({bus.resp0_data, bus.resp0_ovf, bus.resp0_unf}), 32'({24'h408000, 2'b00}));
    repeat (3) tick();

    // Both streaming, sinks ready: strict alternation starting with req1, no stalls.
    acc_log.delete();
    log_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.req0_a = {1'b0, 7'(40 + i), 16'(i * 291)};
      bus.req0_b = {1'b1, 7'(30), 16'(16'h00F0 + i)};
      bus.req1_a = {1'b1, 7'(50 - i), 16'(i * 4660)};
      bus.req1_b = {1'b0, 7'(20 + i), 16'(16'hA500 + i)};
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    log_en = 1'b0;
    repeat (12) tick();
    chk("t2_count", 32'(acc_log.size()), 32'd12);
    for (int i = 0; i < 8; i++) chk("t2_order", 32'(acc_log[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    chk("t2_drain", 32'(exp0_q.size() + exp1_q.size()), 32'd0);

    // resp1 stalled: req1 gets exactly DEPTH acceptances, req0 keeps being served.
    bus.resp1_ready = 1'b0;
    base0 = acc0_n; base1 = acc1_n;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.req0_a = {1'b0, 7'(60), 16'(i)};
      bus.req0_b = {1'b0, 7'(10 + i), 16'(16'h8000 + i)};
      bus.req1_a = {1'b1, 7'(33), 16'(16'h0F00 + i)};
      bus.req1_b = {1'b0, 7'(44), 16'(i * 17)};
      tick();
    end
    chk("t3_acc1", 32'(acc1_n - base1), 32'd4);
    chk("t3_acc0_served", 32'(acc0_n - base0 >= 6), 32'd1);
    chk("t3_rdy1_blocked", 32'(bus.req1_ready), 32'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (12) tick();

    // Credit 0: one pop frees exactly one acceptance.
    bus.req1_a = 24'h3E4321; bus.req1_b = 24'h410101;
    bus.req1_valid = 1'b1; bus.resp1_ready = 1'b1;
    #1;
    chk("t4_rdy_before", 32'(bus.req1_ready), 32'd0);
    chk("t4_rv1", 32'(bus.resp1_valid), 32'd1);
    tick();
    bus.resp1_ready = 1'b0;
    #1;
    chk("t4_rdy_after", 32'(bus.req1_ready), 32'd1);
    base1 = acc1_n;
    tick();
    chk("t4_acc", 32'(acc1_n - base1), 32'd1);
    chk("t4_rdy_zero", 32'(bus.req1_ready), 32'd0);
    bus.req1_valid = 1'b0;
    bus.resp1_ready = 1'b1;
    repeat (12) tick();
    chk("t4_drain", 32'(exp1_q.size()), 32'd0);
    chk("t4_rv1_empty", 32'(bus.resp1_valid), 32'd0);
    // Credit caps at DEPTH after full drain.
    bus.resp1_ready = 1'b0; bus.req1_valid = 1'b1;
    base1 = acc1_n;
    repeat (12) tick();
    chk("t4_cap", 32'(acc1_n - base1), 32'd4);
    bus.req1_valid = 1'b0; bus.resp1_ready = 1'b1;
    repeat (12) tick();

    // Overflow flag rides with its own entry only.
    send(1'b0, 24'h7F1234, 24'h7F0001);
    send(1'b0, 24'h3F8000, 24'h400000);
    send(1'b1, 24'h3F0010, 24'h3F0100);
    wait_valid(1'b0, "t5_wait0a");
    chk("t5_ovf_entry", 32'({bus.resp0_data, bus.resp0_ovf, bus.resp0_unf}), 32'({24'h3F1235, 2'b10}));
    tick();
    wait_valid(1'b0, "t5_wait0b");
    chk("t5_next_entry", 32'({bus.resp0_data, bus.resp0_ovf, bus.resp0_unf}), 32'({24'h408000, 2'b00}));
    wait_valid(1'b1, "t5_wait1");
    chk("t5_resp1", 32'({bus.resp1_data, bus.resp1_ovf, bus.resp1_unf}), 32'({24'h3F0110, 2'b00}));
    repeat (8) tick();

    // Reset with three ops in flight: nothing surfaces afterwards, credits restored.
    send(1'b0, 24'h3F8000, 24'h3F8000);
    send(1'b1, 24'h401111, 24'h3F2222);
    send(1'b0, 24'h423333, 24'h3C4444);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_quiet", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
    end
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    base0 = acc0_n; base1 = acc1_n;
    repeat (12) tick();
    chk("t6_cred0", 32'(acc0_n - base0), 32'd4);
    chk("t6_cred1", 32'(acc1_n - base1), 32'd4);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    repeat (12) tick();
    chk("t6_drain", 32'(exp0_q.size() + exp1_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/fmul_scheduler.md
FMUL_SCHEDULER -- requirements
Module: fmul_scheduler

Interface
REQ-001 Parameter LATENCY, default 4, means cycles from operands on mul_a/mul_b to matching result on mul_result; legal range 1..15.
REQ-002 Parameter DEPTH, default 4, means per-requester response FIFO entries; power of two, 2..16.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Ports req0_valid / req1_valid  in  1  requester N offers an operand pair.
REQ-006 Ports req0_ready / req1_ready  out  1  scheduler accepts requester N's pair this cycle.
REQ-007 Ports req0_a, req0_b, req1_a, req1_b  in  24  operands: sign[23], exponent[22:16], mantissa[15:0].
REQ-008 Ports mul_a / mul_b  out  24  registered operands driven to the shared multiplier.
REQ-009 Ports mul_result  in  24; mul_overflow / mul_underflow  in  1  multiplier outputs; no stall input.
REQ-010 Ports resp0_valid / resp1_valid  out  1; resp0_ready / resp1_ready  in  1  response handshake per requester.
REQ-011 Ports resp0_data / resp1_data  out  24; resp0_ovf, resp0_unf, resp1_ovf, resp1_unf  out  1  result and flags.

Function
REQ-012 A request is accepted on a rising edge where reqN_valid and reqN_ready are both 1; at most one acceptance per cycle.
REQ-013 reqN_ready = grant_N AND credit_N > 0; ready is combinational from state and both valids; no combinational path from resp ports.
REQ-014 Arbitration is round-robin: pointer selects preferred requester; if preferred is valid with credit, it is granted, else the other if valid with credit.
REQ-015 After an acceptance, the pointer moves to the non-accepted requester; with no acceptance it is unchanged.
REQ-016 On acceptance, mul_a/mul_b load the winner's operands at that edge; otherwise they hold their value.
REQ-017 A tag pipeline of LATENCY stages carries {valid, id}; an accepted op enters valid=1 with its id, idle cycles enter valid=0.
REQ-018 When the tag exiting the pipeline is valid, {mul_result, mul_overflow, mul_underflow} is written into FIFO[id] on that edge.
REQ-019 Latency: accept at edge E -> respN_valid=1 in the cycle after edge E+LATENCY+1, i.e. LATENCY+2 cycles after acceptance.
REQ-020 Per requester, responses return in acceptance order; data, ovf and unf are unmodified from the multiplier.
REQ-021 credit_N starts at DEPTH; -1 on acceptance for N, +1 on respN handshake, unchanged when both occur in one cycle.
REQ-022 credit_N never goes below 0 or above DEPTH; the FIFO therefore never overflows and the multiplier never needs stalling.
REQ-023 respN_valid = FIFO[N] not empty; data/flags show FIFO head; popped on respN_valid AND respN_ready.
REQ-024 Simultaneous push and pop on one FIFO, including when full or empty-with-push, both take effect; an empty FIFO pushed and not popped presents valid next cycle.
REQ-025 FIFO pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
REQ-026 With both requesters' credit at 0, both ready are 0 and only idle tags enter the pipeline.

Reset
REQ-027 While rst=1: req0_ready, req1_ready, resp0_valid, resp1_valid = 0; mul_a, mul_b, resp data and flags = 0.
REQ-028 Reset sets credits to DEPTH, FIFOs empty, all tag valids to 0, pointer to requester 0.
REQ-029 Operations in flight at reset are discarded; no result arriving after reset release is written to any FIFO.

Structure
REQ-030 Shared package fmul_pkg holds FLOAT_W=24, EXP_W=7, MANT_W=16, field bit positions, and the response record width (26).
REQ-031 One sub-module fmul_resp_fifo (DEPTH x 26 bits, push/pop/full/empty, async reset) is instantiated twice.
REQ-032 Arbiter, credit counters and tag pipeline reside in fmul_scheduler; no other sub-modules.

Verification
REQ-033 req0 alone, a=24'h3F8000, b=24'h400000, bench multiplier model LATENCY=4 -> mul_a=24'h3F8000 one cycle after accept; resp0_valid 6 cycles after accept with model result.
REQ-034 Both valid every cycle, resp ready=1 -> acceptances alternate 0,1,0,1; each resp stream in order, no gaps after fill.
REQ-035 resp1_ready=0, req1 streaming -> exactly 4 req1 acceptances then req1_ready=0; req0 still served every cycle.
REQ-036 Credit 0, then resp1_ready=1 and req1_valid=1 in one cycle -> one pop; req1 acceptance next cycle; credit never exceeds 4.
REQ-037 mul_overflow=1 on a req0 result -> resp0_ovf=1 on that entry only; resp0_unf and resp1 flags unaffected.
REQ-038 rst pulsed with 3 ops in flight -> both resp_valid stay 0 after release for 10 cycles; credits back to 4.
